ps2_host_rx: RTL

- Host-side PS/2 receiver and scancode decoder for cores that consume the emulated keyboard lines driven by the ARM-to-FPGA IO block.
- Deserialises PS/2 frames from ps2_kbd_clk/ps2_kbd_data into bytes, checks parity and framing, and recovers from stalled frames.
- Assembles scancode sequences (E0, F0, E1 prefixes) into single key events in the core's 11-bit ps2_key format.

---
 rtl/ps2_host_rx_if.sv | 34 +++
 rtl/ps2_host_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_rx_if.sv
// Signal bundle between a PS/2 device line pair and the host receiver/decoder.
// The receiver is the master of the decoded byte/key stream; the consumer is the slave.
interface ps2_host_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic [10:0] ps2_key;
    logic        key_strobe;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output rx_byte,
        output rx_valid,
        output parity_err,
        output frame_err,
        output ps2_key,
        output key_strobe
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  rx_byte,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  ps2_key,
        input  key_strobe
    );
endinterface

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: synchronise and filter the line clock, deserialise
// 11-bit frames, then fold E0/F0/E1 scancode sequences into single ps2_key events.
module ps2_host_rx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk_sys,
    input  logic           reset,
    ps2_host_rx_if.master  bus
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f, clk_f_d;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_bit, par_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          byte_ok, perr_set, ferr_set;

    logic [7:0]    rx_byte_q;
    logic          rx_valid_q, parity_err_q, frame_err_q;

    logic          ext, ext_n, brk, brk_n;
    logic [2:0]    skip, skip_n;
    logic          emit, noise;
    logic [9:0]    ev;
    logic [10:0]   key_q;
    logic          strobe_q;

    assign bus.rx_byte    = rx_byte_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.ps2_key    = key_q;
    assign bus.key_strobe = strobe_q;

    assign fall = clk_f_d & ~clk_f;

    // Filtered clock follows the synchronised clock only after FILTER consecutive disagreeing cycles.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_f    <= 1'b1;
            clk_f_d  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1  <= bus.ps2_clk;
            clk_s2  <= clk_s1;
            dat_s1  <= bus.ps2_data;
            dat_s2  <= dat_s1;
            clk_f_d <= clk_f;
            if (clk_s2 != clk_f) begin
                if (filt_cnt == FILT_LAST) begin
                    clk_f    <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par_bit;
        byte_ok   = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;

        if (fall || state == S_IDLE)
            to_cnt_n = '0;
        else if (to_cnt != '1)
            to_cnt_n = to_cnt + 1'b1;
        else
            to_cnt_n = to_cnt;

        // A fall in the same cycle as the timeout takes priority.
        if (fall) begin
            unique case (state)
                S_IDLE: begin
                    if (!dat_s2) begin
                        state_n   = S_DATA;
                        bit_cnt_n = '0;
                    end
                end
                S_DATA: begin
                    shreg_n   = {dat_s2, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = S_PARITY;
                end
                S_PARITY: begin
                    par_n   = dat_s2;
                    state_n = S_STOP;
                end
                S_STOP: begin
                    if (!dat_s2)
                        ferr_set = 1'b1;
                    else if (^{shreg, par_bit})
                        byte_ok = 1'b1;
                    else
                        perr_set = 1'b1;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end else if (state != S_IDLE && to_cnt == TO_LAST) begin
            state_n  = S_IDLE;
            ferr_set = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            to_cnt       <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            par_bit      <= par_n;
            to_cnt       <= to_cnt_n;
            rx_valid_q   <= byte_ok;
            parity_err_q <= perr_set;
            frame_err_q  <= ferr_set;
            if (byte_ok)
                rx_byte_q <= shreg;
        end
    end

    always_comb begin
        unique case (rx_byte_q)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: noise = 1'b1;
            default:                                  noise = 1'b0;
        endcase
    end

    // Pause (E1 ...) is a fixed 8-byte sequence: skip the next 7 bytes and emit on the last.
    always_comb begin
        ext_n  = ext;
        brk_n  = brk;
        skip_n = skip;
        emit   = 1'b0;
        ev     = '0;
        if (rx_valid_q) begin
            if (skip != 3'd0) begin
                skip_n = skip - 3'd1;
                if (skip == 3'd1) begin
                    emit = 1'b1;
                    ev   = {1'b1, 1'b1, 8'h77};
                end
            end else if (rx_byte_q == 8'hE1) begin
                skip_n = 3'd7;
            end else if (rx_byte_q == 8'hE0) begin
                ext_n = 1'b1;
            end else if (rx_byte_q == 8'hF0) begin
                brk_n = 1'b1;
            end else if (!(noise && !ext && !brk)) begin
                ext_n = 1'b0;
                brk_n = 1'b0;
                if (!(ext && rx_byte_q == 8'h12)) begin
                    emit = 1'b1;
                    ev   = {~brk, ext, rx_byte_q};
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ext      <= 1'b0;
            brk      <= 1'b0;
            skip     <= '0;
            key_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            ext      <= ext_n;
            brk      <= brk_n;
            skip     <= skip_n;
            strobe_q <= emit;
            if (emit)
                key_q <= {~key_q[10], ev};
        end
    end

endmodule
